// File: rtl/bus_slave_pkg.sv
// Shared types, constants and address helpers for the SRAM bus slave.
package bus_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdBurst,
    StRdEnd,
    StWr,
    StWrErr,
    StRdErr
  } state_t;

  // Remaining-beat counter width: burstSize+1 can reach 256.
  localparam int unsigned BEAT_W = 9;

  // The bus is wired-OR, so an idle slave drives all zeros.
  localparam logic [31:0] BUS_DATA_IDLE = 32'h0;
  localparam logic        BUS_CTRL_IDLE = 1'b0;

  // Byte address falls inside the 2^(addr_bits+2)-byte window at base.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned addr_bits);
    return (addr >> (addr_bits + 2)) == (base >> (addr_bits + 2));
  endfunction

  // Burst would run past the last word; computed wide so it cannot wrap.
  function automatic logic range_err(input logic [31:0] start_word, input logic [7:0] burst,
                                     input int unsigned addr_bits);
    logic [31:0] end_word;
    end_word = start_word + {24'h0, burst} + 32'd1;
    return end_word > (32'd1 << addr_bits);
  endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Single-port synchronous SRAM with per-byte write enables and a one-cycle read.
// The read register returns to idle (zero) on cycles without a read so it can
// drive the wired-OR bus directly.
module bus_slave_ram
  import bus_slave_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read_en,
  input  logic [3:0]           write_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data
);

  logic [31:0] mem [2**ADDR_BITS];

  // Byte-lane writes; contents are not reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (write_en[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
    end
  end

  // Registered read data, zero when no read was issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data <= BUS_DATA_IDLE;
    end else begin
      read_data <= read_en ? mem[addr] : BUS_DATA_IDLE;
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// Burst bus slave backed by an on-chip SRAM window at BASE_ADDR.
// SRAM reads are issued one cycle before the beat they feed, so read beats
// are back-to-back and every output comes straight from a register.
module bus_sram_slave
  import bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h5000_0000,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned WRITE_THROTTLE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam logic [3:0]           LatInit = 4'(READ_LATENCY - 1);
  localparam logic [ADDR_BITS-1:0] WordOne = 1;
  localparam logic [BEAT_W-1:0]    BeatOne = 1;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] word_q, word_d;
  logic [BEAT_W-1:0]    beats_q, beats_d;
  logic [3:0]           lat_q, lat_d;
  logic [3:0]           be_q, be_d;
  logic                 valid_q, end_q, err_q, busy_q, busy_d;

  logic                 ram_re;
  logic [3:0]           ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [ADDR_BITS-1:0] start_word;
  logic                 hit, err, accept;

  assign start_word = addressDataIn[ADDR_BITS+1:2];
  assign hit        = beginTransactionIn && addr_hit(addressDataIn, BASE_ADDR, ADDR_BITS);
  assign err        = range_err({{(32-ADDR_BITS){1'b0}}, start_word}, burstSizeIn, ADDR_BITS);
  assign accept     = (state_q == StWr) && dataValidIn && !busy_q;

  // Next-state, SRAM control and address/beat bookkeeping.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    beats_d  = beats_q;
    lat_d    = lat_q;
    be_d     = be_q;
    busy_d   = 1'b0;
    ram_re   = 1'b0;
    ram_we   = 4'h0;
    ram_addr = word_q;
    unique case (state_q)
      StIdle: begin
        ram_addr = start_word;
        if (hit) begin
          word_d  = start_word;
          beats_d = {1'b0, burstSizeIn} + BeatOne;
          be_d    = byteEnablesIn;
          lat_d   = LatInit;
          if (readNotWriteIn) begin
            if (err) begin
              state_d = StRdErr;
            end else if (READ_LATENCY <= 1) begin
              // First beat must be read now to appear next cycle.
              state_d = StRdBurst;
              ram_re  = 1'b1;
              word_d  = start_word + WordOne;
              beats_d = {1'b0, burstSizeIn};
            end else begin
              state_d = StRdWait;
            end
          end else begin
            state_d = err ? StWrErr : StWr;
          end
        end
      end
      StRdWait: begin
        if (lat_q == 4'd1) begin
          state_d = StRdBurst;
          ram_re  = 1'b1;
          word_d  = word_q + WordOne;
          beats_d = beats_q - BeatOne;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StRdBurst: begin
        if (beats_q == '0) begin
          state_d = StRdEnd;
        end else begin
          ram_re  = 1'b1;
          word_d  = word_q + WordOne;
          beats_d = beats_q - BeatOne;
        end
      end
      StRdEnd, StRdErr: state_d = StIdle;
      StWr: begin
        // Excess beats are dropped; the word pointer stops on the last word.
        if (accept && beats_q != '0) begin
          ram_we  = be_q;
          beats_d = beats_q - BeatOne;
          if (beats_q != BeatOne) word_d = word_q + WordOne;
        end
        if (endTransactionIn) state_d = StIdle;
        busy_d = (WRITE_THROTTLE != 0) && accept && !endTransactionIn;
      end
      StWrErr: begin
        if (endTransactionIn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      be_q    <= '0;
      valid_q <= BUS_CTRL_IDLE;
      end_q   <= BUS_CTRL_IDLE;
      err_q   <= BUS_CTRL_IDLE;
      busy_q  <= BUS_CTRL_IDLE;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      be_q    <= be_d;
      valid_q <= (state_d == StRdBurst);
      end_q   <= (state_d == StRdEnd) || (state_d == StRdErr);
      err_q   <= (state_d == StRdErr) || (state_q == StIdle && state_d == StWrErr);
      busy_q  <= busy_d;
    end
  end

  bus_slave_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .read_en   (ram_re),
    .write_en  (ram_we),
    .addr      (ram_addr),
    .write_data(addressDataIn),
    .read_data (addressDataOut)
  );

  assign dataValidOut      = valid_q;
  assign endTransactionOut = end_q;
  assign busErrorOut       = err_q;
  assign busyOut           = busy_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench: two slaves share the bus inputs, one without and one with
// write throttling; each step checks hand-computed outputs.
module tb_bus_sram_slave;

  localparam logic [31:0] Base = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        begin_t, rnw, dv, et;
  logic [31:0] ad;
  logic [3:0]  be;
  logic [7:0]  bs;

  logic [1:0][31:0] ad_o;
  logic [1:0]       dv_o, et_o, er_o, by_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bus_sram_slave #(
    .BASE_ADDR(Base), .ADDR_BITS(10), .READ_LATENCY(2), .WRITE_THROTTLE(0)
  ) dut (
    .clock(clock), .reset(reset), .beginTransactionIn(begin_t), .addressDataIn(ad),
    .byteEnablesIn(be), .burstSizeIn(bs), .readNotWriteIn(rnw), .dataValidIn(dv),
    .endTransactionIn(et), .addressDataOut(ad_o[0]), .dataValidOut(dv_o[0]),
    .endTransactionOut(et_o[0]), .busErrorOut(er_o[0]), .busyOut(by_o[0])
  );

  bus_sram_slave #(
    .BASE_ADDR(Base), .ADDR_BITS(10), .READ_LATENCY(2), .WRITE_THROTTLE(1)
  ) dut_t (
    .clock(clock), .reset(reset), .beginTransactionIn(begin_t), .addressDataIn(ad),
    .byteEnablesIn(be), .burstSizeIn(bs), .readNotWriteIn(rnw), .dataValidIn(dv),
    .endTransactionIn(et), .addressDataOut(ad_o[1]), .dataValidOut(dv_o[1]),
    .endTransactionOut(et_o[1]), .busErrorOut(er_o[1]), .busyOut(by_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] all_out(input int w);
    return {28'h0, ad_o[w], dv_o[w], et_o[w], er_o[w], by_o[w]};
  endfunction

  task automatic idle_bus();
    begin_t = 0; rnw = 0; dv = 0; et = 0; ad = 0; be = 0; bs = 0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] ben, input int n,
                           input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    begin_t = 1; ad = addr; bs = 8'(n - 1); rnw = 0; be = ben;
    tick();
    begin_t = 0;
    for (int i = 0; i < n; i++) begin
      chk("wr err", 64'(er_o[0]), 64'd0);
      chk("wr busy", 64'(by_o[0]), 64'd0);
      dv = 1; ad = d[i]; et = (i == n - 1);
      tick();
    end
    idle_bus();
  endtask

  // Latency 2: one silent cycle, n beats, then one end cycle.
  task automatic bus_read(input int w, input logic [31:0] addr, input int n,
                          input logic [31:0] e0, e1, e2, e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    begin_t = 1; ad = addr; bs = 8'(n - 1); rnw = 1;
    tick();
    idle_bus();
    chk("rd wait dv", 64'(dv_o[w]), 64'd0);
    chk("rd wait data", 64'(ad_o[w]), 64'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk("rd beat dv", 64'(dv_o[w]), 64'd1);
      chk("rd beat data", 64'(ad_o[w]), 64'(e[i]));
      chk("rd beat end", 64'(et_o[w]), 64'd0);
      tick();
    end
    chk("rd end", all_out(w), {28'h0, 32'h0, 4'b0100});
    tick();
    chk("rd after end", all_out(w), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_bus();
    #3;
    chk("reset dut", all_out(0), 64'd0);
    chk("reset dut_t", all_out(1), 64'd0);
    tick();
    tick();
    reset = 0;
    tick();

    // 1. Burst write then 2. read back with exact timing.
    bus_write(Base + 32'h10, 4'hF, 4, 32'h11, 32'h22, 32'h33, 32'h44);
    bus_read(0, Base + 32'h10, 4, 32'h11, 32'h22, 32'h33, 32'h44);

    // 3. Byte enables over a cleared word.
    bus_write(Base, 4'hF, 1, 32'h0, 0, 0, 0);
    bus_write(Base, 4'b0101, 1, 32'hAABB_CCDD, 0, 0, 0);
    bus_read(0, Base, 1, 32'h00BB_00DD, 0, 0, 0);

    // 4. Last word is legal alone; a 2-beat burst from it is a range error.
    bus_write(Base + 32'hFFC, 4'hF, 1, 32'h1234_5678, 0, 0, 0);
    begin_t = 1; ad = Base + 32'hFFC; bs = 8'd1; rnw = 1;
    tick();
    idle_bus();
    chk("rd range err", all_out(0), {28'h0, 32'h0, 4'b0110});
    tick();
    chk("rd range after", all_out(0), 64'd0);
    begin_t = 1; ad = Base + 32'hFFC; bs = 8'd1; rnw = 0; be = 4'hF;
    tick();
    begin_t = 0;
    chk("wr range err", all_out(0), {28'h0, 32'h0, 4'b0010});
    dv = 1; ad = 32'hDEAD_BEEF;
    tick();
    chk("wr range err once", all_out(0), 64'd0);
    ad = 32'hCAFE_F00D; et = 1;
    tick();
    idle_bus();
    chk("wr range idle", all_out(0), 64'd0);
    bus_read(0, Base + 32'hFFC, 1, 32'h1234_5678, 0, 0, 0);

    // 5. Miss just past the window.
    begin_t = 1; ad = Base + 32'h1000; bs = 8'd0; rnw = 1;
    tick();
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      chk("miss quiet", all_out(0), 64'd0);
      tick();
    end

    // 6a. Throttled write, master holding each beat during busy.
    begin_t = 1; ad = Base + 32'h40; bs = 8'd3; rnw = 0; be = 4'hF;
    tick();
    begin_t = 0;
    dv = 1;
    for (int c = 0; c < 7; c++) begin
      chk("throttle busy", 64'(by_o[1]), 64'(c % 2));
      ad = 32'hA1 + 32'(c / 2);
      et = (c == 6);
      tick();
    end
    idle_bus();
    chk("throttle busy idle", 64'(by_o[1]), 64'd0);
    bus_read(1, Base + 32'h40, 4, 32'hA1, 32'hA2, 32'hA3, 32'hA4);

    // 6b. Reset in the middle of an 8-beat read.
    begin_t = 1; ad = Base + 32'h10; bs = 8'd7; rnw = 1;
    tick();
    idle_bus();
    tick();
    chk("pre-reset beat", 64'(dv_o[0]), 64'd1);
    tick();
    #2 reset = 1;
    #1;
    chk("reset mid-burst", all_out(0), 64'd0);
    tick();
    reset = 0;
    tick();
    chk("post-reset idle", all_out(0), 64'd0);
    tick();
    chk("post-reset idle 2", all_out(0), 64'd0);
    bus_write(Base + 32'h20, 4'hF, 1, 32'h0BAD_F00D, 0, 0, 0);
    bus_read(0, Base + 32'h20, 1, 32'h0BAD_F00D, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
